car_direction_detector: RTL and testbench
=========================================

CAR_DIRECTION_DETECTOR -- requirements
Module: car_direction_detector

Interface
REQ-001 The block SHALL have parameter DEBOUNCE, default 4, giving the number of consecutive samples a sensor level must hold before it is accepted.
REQ-002 The block SHALL have parameter TIMEOUT, default 1000, giving the maximum number of cycles a crossing may stay without a state change.
REQ-003 Port clk, input, 1 bit: the single clock; all logic updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port sensA, input, 1 bit: asynchronous outer photo-sensor; 1 means the beam is blocked.
REQ-006 Port sensB, input, 1 bit: asynchronous inner photo-sensor; 1 means the beam is blocked.
REQ-007 Port carIn, output, 1 bit: registered one-cycle pulse marking one completed entry; it feeds the downstream car counter.
REQ-008 Port carOut, output, 1 bit: registered one-cycle pulse marking one completed exit; it feeds the downstream car counter.
REQ-009 Port err, output, 1 bit: registered one-cycle pulse marking an illegal sequence or a timeout.
REQ-010 Port busy, output, 1 bit: registered; high whenever the FSM is not in IDLE.

Function
REQ-011 Each sensor SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-012 Each synchronized sensor SHALL have its own debounce counter and filtered register fA/fB:
- While the synchronized value differs from the filtered value, the counter increments.
- While they are equal, the counter clears to 0.
- On the edge where the counter equals DEBOUNCE-1 and the values still differ, the filtered register takes the new value and the counter clears.
REQ-013 Glitches shorter than DEBOUNCE samples SHALL never reach fA/fB.
REQ-014 FSM states SHALL be IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A and WAIT_CLEAR; fA/fB below is written as the pair {fA,fB}.
REQ-015 From IDLE: {1,0} goes to EN_A, {0,1} goes to EX_B, {0,0} stays in IDLE, and {1,1} goes to WAIT_CLEAR with an err pulse.
REQ-016 The entry path SHALL be EN_A -> EN_AB on {1,1}, then EN_AB -> EN_B on {0,1}, then EN_B -> IDLE on {0,0}, which pulses carIn.
REQ-017 The exit path SHALL be EX_B -> EX_BA on {1,1}, then EX_BA -> EX_A on {1,0}, then EX_A -> IDLE on {0,0}, which pulses carOut.
REQ-018 Backing up one step SHALL be legal with no pulse on either path:
- Entry: EN_AB -> EN_A on {1,0}; EN_B -> EN_AB on {1,1}; EN_A -> IDLE on {0,0} (car backed out).
- Exit: EX_BA -> EX_B on {0,1}; EX_A -> EX_BA on {1,1}; EX_B -> IDLE on {0,0}.
REQ-019 Any other pair change while in an EN_* or EX_* state SHALL move the FSM to WAIT_CLEAR and pulse err, e.g. EN_A on {0,1}, or EN_AB or EX_BA on {0,0}.
REQ-020 WAIT_CLEAR SHALL stay in WAIT_CLEAR until {0,0}, then go to IDLE with no pulse; no carIn or carOut pulse is produced in or on leaving WAIT_CLEAR.
REQ-021 A timeout counter SHALL run in every EN_* and EX_* state and clear on every state change.
REQ-022 When the timeout counter reaches TIMEOUT-1, the FSM SHALL go to WAIT_CLEAR with an err pulse.
REQ-023 The timeout counter SHALL be wide enough for TIMEOUT and SHALL never wrap.
REQ-024 carIn, carOut and err SHALL each be high for exactly one cycle per event and SHALL never be high at the same time.
REQ-025 busy SHALL be registered alongside the next state.
REQ-026 Latency SHALL be DEBOUNCE+3 rising edges, counting from the edge that first samples the final raw level up to the edge after which carIn or carOut is high.
REQ-027 Back-to-back cars SHALL be counted: after a pulse, the FSM is in IDLE and accepts a new {1,0} or {0,1} on the very next filtered change.

Reset
REQ-028 While reset is high at a clock edge, the block SHALL clear:
- the synchronizers, fA/fB, and the debounce and timeout counters to 0;
- the FSM to IDLE;
- carIn, carOut, err and busy to 0.
REQ-029 A reset in the middle of a crossing SHALL discard it; no pulse is produced for that car.
REQ-030 After reset is released, sensors that are still blocked SHALL be handled by the normal transitions; {1,1} leads to WAIT_CLEAR with err.

Verification (DEBOUNCE=4, TIMEOUT=64)
REQ-031 Entry: sensA/sensB stepped 00,10,11,01,00, each held 20 cycles -> exactly one carIn pulse, 7 edges after the final 00 is first sampled; carOut=0 and err=0.
REQ-032 Exit: 00,01,11,10,00, each held 20 cycles -> exactly one carOut pulse; busy returns to 0 on the same edge.
REQ-033 Glitch rejection: a 3-cycle pulse on sensA with sensB=0 -> fA never changes, busy stays 0, and no pulses occur.
REQ-034 Illegal and timeout:
- 00 then 11 together -> one err pulse, FSM in WAIT_CLEAR, no count pulse.
- 10 held for 100 cycles -> one err pulse at the timeout, then IDLE once the pair returns to 00.
REQ-035 Reversal and reset:
- 00,10,11,10,00 -> no pulses at all.
- reset asserted during EN_AB -> all outputs are 0 on the next edge, and a following full entry yields exactly one carIn.
REQ-036 Eight consecutive entries followed by eight exits SHALL produce exactly 8 carIn pulses and then 8 carOut pulses.

Source files
------------

// File: rtl/car_direction_detector.sv
// Car direction detector for a two-beam gate (outer sensor A, inner sensor B).
// Sensors are synchronized and debounced, then an FSM follows the beam pattern
// and emits one-cycle carIn / carOut / err pulses plus a busy level.
module car_direction_detector #(
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensA,
  input  logic sensB,
  output logic carIn,
  output logic carOut,
  output logic err,
  output logic busy
);

  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    EN_A,
    EN_AB,
    EN_B,
    EX_B,
    EX_BA,
    EX_A,
    WAIT_CLEAR
  } state_t;

  // index 0 is sensor A, index 1 is sensor B
  logic [1:0]      raw;
  logic [1:0][1:0] sync;
  logic [1:0]      filt;
  logic [DB_W-1:0] db_cnt [2];

  logic            fa;
  logic            fb;
  logic [1:0]      pair;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] tcnt;
  logic            crossing;
  logic            illegal;
  logic            car_in_c;
  logic            car_out_c;
  logic            err_c;

  assign raw  = {sensB, sensA};
  assign fa   = filt[0];
  assign fb   = filt[1];
  assign pair = {fa, fb};

  // Two-flop synchronizer and per-sensor debounce filter
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sync[i]   <= 2'b00;
        filt[i]   <= 1'b0;
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync[i] <= {sync[i][0], raw[i]};
        if (sync[i][1] == filt[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DEBOUNCE - 1)) begin
          filt[i]   <= sync[i][1];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign crossing = (state != IDLE) && (state != WAIT_CLEAR);

  // Next-state and pulse decode from the filtered sensor pair
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    car_in_c  = 1'b0;
    car_out_c = 1'b0;
    err_c     = 1'b0;

    case (state)
      IDLE: begin
        case (pair)
          2'b10:   state_nxt = EN_A;
          2'b01:   state_nxt = EX_B;
          2'b00:   state_nxt = IDLE;
          default: illegal   = 1'b1;
        endcase
      end
      EN_A: begin
        case (pair)
          2'b10:   state_nxt = EN_A;
          2'b11:   state_nxt = EN_AB;
          2'b00:   state_nxt = IDLE;
          default: illegal   = 1'b1;
        endcase
      end
      EN_AB: begin
        case (pair)
          2'b11:   state_nxt = EN_AB;
          2'b01:   state_nxt = EN_B;
          2'b10:   state_nxt = EN_A;
          default: illegal   = 1'b1;
        endcase
      end
      EN_B: begin
        case (pair)
          2'b01:   state_nxt = EN_B;
          2'b11:   state_nxt = EN_AB;
          2'b00: begin
            state_nxt = IDLE;
            car_in_c  = 1'b1;
          end
          default: illegal   = 1'b1;
        endcase
      end
      EX_B: begin
        case (pair)
          2'b01:   state_nxt = EX_B;
          2'b11:   state_nxt = EX_BA;
          2'b00:   state_nxt = IDLE;
          default: illegal   = 1'b1;
        endcase
      end
      EX_BA: begin
        case (pair)
          2'b11:   state_nxt = EX_BA;
          2'b10:   state_nxt = EX_A;
          2'b01:   state_nxt = EX_B;
          default: illegal   = 1'b1;
        endcase
      end
      EX_A: begin
        case (pair)
          2'b10:   state_nxt = EX_A;
          2'b11:   state_nxt = EX_BA;
          2'b00: begin
            state_nxt = IDLE;
            car_out_c = 1'b1;
          end
          default: illegal   = 1'b1;
        endcase
      end
      WAIT_CLEAR: begin
        if (pair == 2'b00) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // a pair-driven move wins over a timeout landing on the same cycle
    if (illegal) begin
      state_nxt = WAIT_CLEAR;
      err_c     = 1'b1;
    end else if (crossing && (state_nxt == state) && (tcnt == TO_W'(TIMEOUT - 1))) begin
      state_nxt = WAIT_CLEAR;
      err_c     = 1'b1;
    end
  end

  // State, timeout counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tcnt   <= '0;
      carIn  <= 1'b0;
      carOut <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      carIn  <= car_in_c;
      carOut <= car_out_c;
      err    <= err_c;
      busy   <= (state_nxt != IDLE);
      if (crossing && (state_nxt == state)) begin
        tcnt <= tcnt + TO_W'(1);
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_car_direction_detector.sv
// Self-checking bench for car_direction_detector with a path-position
// reference model and randomized sensor sequences.
module tb_car_direction_detector;

  localparam int DEBOUNCE = 4;
  localparam int TIMEOUT  = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sensA = 1'b0;
  logic sensB = 1'b0;
  logic carIn, carOut, err, busy;

  int total = 0;
  int bad   = 0;

  car_direction_detector #(.DEBOUNCE(DEBOUNCE), .TIMEOUT(TIMEOUT)) dut (
    .clk    (clk),
    .reset  (reset),
    .sensA  (sensA),
    .sensB  (sensB),
    .carIn  (carIn),
    .carOut (carOut),
    .err    (err),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 entering, 2 exiting, 3 waiting for clear
  // pos : index along the crossing path 00 -> p1 -> p2 -> p3 -> 00
  logic [1:0] m_sa = 2'b00, m_sb = 2'b00;
  logic       m_fa = 1'b0, m_fb = 1'b0;
  bit         hq_a[$];
  bit         hq_b[$];
  int         m_mode = 0, m_pos = 0, m_age = 0;
  logic       m_in = 1'b0, m_out = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic [1:0] m_pr;
  bit         all_a, all_b;

  function automatic logic [1:0] path_pair(input int dir, input int pos);
    if (pos <= 0 || pos >= 4) return 2'b00;
    if (pos == 2) return 2'b11;
    if (dir == 1) return (pos == 1) ? 2'b10 : 2'b01;
    return (pos == 1) ? 2'b01 : 2'b10;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_sa = 2'b00; m_sb = 2'b00; m_fa = 1'b0; m_fb = 1'b0;
      hq_a.delete(); hq_b.delete();
      m_mode = 0; m_pos = 0; m_age = 0;
      m_in = 1'b0; m_out = 1'b0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      m_pr = {m_fa, m_fb};
      m_in = 1'b0; m_out = 1'b0; m_err = 1'b0;
      if (m_mode == 0) begin
        m_age = 0;
        if (m_pr == 2'b10) begin m_mode = 1; m_pos = 1; end
        else if (m_pr == 2'b01) begin m_mode = 2; m_pos = 1; end
        else if (m_pr == 2'b11) begin m_mode = 3; m_err = 1'b1; end
      end else if (m_mode == 3) begin
        if (m_pr == 2'b00) m_mode = 0;
      end else begin
        if (m_pr == path_pair(m_mode, m_pos)) begin
          if (m_age == TIMEOUT - 1) begin m_mode = 3; m_err = 1'b1; m_age = 0; end
          else m_age++;
        end else if (m_pr == path_pair(m_mode, m_pos + 1)) begin
          m_age = 0;
          if (m_pos == 3) begin
            if (m_mode == 1) m_in = 1'b1; else m_out = 1'b1;
            m_mode = 0;
          end else m_pos++;
        end else if (m_pr == path_pair(m_mode, m_pos - 1)) begin
          m_age = 0;
          if (m_pos == 1) m_mode = 0; else m_pos--;
        end else begin
          m_mode = 3; m_err = 1'b1; m_age = 0;
        end
      end
      m_busy = (m_mode != 0);
      // filtered level flips once the last DEBOUNCE synced samples all disagree with it
      hq_a.push_back(m_sa[1]); if (hq_a.size() > DEBOUNCE) void'(hq_a.pop_front());
      hq_b.push_back(m_sb[1]); if (hq_b.size() > DEBOUNCE) void'(hq_b.pop_front());
      all_a = (hq_a.size() == DEBOUNCE); all_b = (hq_b.size() == DEBOUNCE);
      foreach (hq_a[k]) if (hq_a[k] == m_fa) all_a = 0;
      foreach (hq_b[k]) if (hq_b[k] == m_fb) all_b = 0;
      if (all_a) m_fa = ~m_fa;
      if (all_b) m_fb = ~m_fb;
      m_sa = {m_sa[0], sensA};
      m_sb = {m_sb[0], sensB};
    end
  end

  // ---------------- observation counters ----------------
  bit mon_en = 0;
  int diverge = 0, overlap = 0;
  int d_in = 0, d_out = 0, d_err = 0;
  int e_in = 0, e_out = 0, e_err = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if ({carIn, carOut, err, busy} !== {m_in, m_out, m_err, m_busy}) diverge++;
      if ((int'(carIn === 1'b1) + int'(carOut === 1'b1) + int'(err === 1'b1)) > 1) overlap++;
      if (carIn === 1'b1) d_in++;
      if (carOut === 1'b1) d_out++;
      if (err === 1'b1) d_err++;
      if (m_in) e_in++;
      if (m_out) e_out++;
      if (m_err) e_err++;
    end
  end

  task automatic hold(input logic [1:0] p, input int n);
    sensA = p[1];
    sensB = p[0];
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; sensA = 1'b0; sensB = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({carIn, carOut, err, busy} !== 4'b0000) begin bad++; $display("FAIL reset_outputs: got=%b exp=0000", {carIn, carOut, err, busy}); end
    total++; if ({dut.fa, dut.fb} !== 2'b00) begin bad++; $display("FAIL reset_filters: got=%b exp=00", {dut.fa, dut.fb}); end
    reset = 1'b0;
    mon_en = 1;
    hold(2'b00, 10);
  endtask

  task automatic test_entry();
    int i0, o0, r0, v0, lat, n;
    i0 = d_in; o0 = d_out; r0 = d_err; v0 = diverge;
    hold(2'b00, 20); hold(2'b10, 20); hold(2'b11, 20); hold(2'b01, 20);
    sensA = 1'b0; sensB = 1'b0;
    lat = -1; n = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (carIn === 1'b1) begin n++; if (lat < 0) lat = e; end
    end
    @(negedge clk);
    total++; if (lat !== DEBOUNCE + 3) begin bad++; $display("FAIL entry_latency: got=%0d exp=%0d", lat, DEBOUNCE + 3); end
    total++; if (n !== 1) begin bad++; $display("FAIL entry_pulse_width: got=%0d exp=1", n); end
    total++; if (d_in - i0 !== 1) begin bad++; $display("FAIL entry_carIn: got=%0d exp=1", d_in - i0); end
    total++; if ((d_out - o0) + (d_err - r0) !== 0) begin bad++; $display("FAIL entry_other_pulses: got=%0d exp=0", (d_out - o0) + (d_err - r0)); end
    total++; if (diverge - v0 !== 0) begin bad++; $display("FAIL entry_model: got=%0d exp=0", diverge - v0); end
  endtask

  task automatic test_exit();
    int i0, o0, r0, v0, n;
    logic b_at, b_prev, b_last;
    i0 = d_in; o0 = d_out; r0 = d_err; v0 = diverge;
    hold(2'b00, 20); hold(2'b01, 20); hold(2'b11, 20); hold(2'b10, 20);
    sensA = 1'b0; sensB = 1'b0;
    n = 0; b_at = 1'bx; b_prev = 1'bx; b_last = busy;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (carOut === 1'b1) begin n++; b_at = busy; b_prev = b_last; end
      b_last = busy;
    end
    @(negedge clk);
    total++; if (d_out - o0 !== 1) begin bad++; $display("FAIL exit_carOut: got=%0d exp=1", d_out - o0); end
    total++; if ({b_prev, b_at} !== 2'b10) begin bad++; $display("FAIL exit_busy_drop: got=%b exp=10", {b_prev, b_at}); end
    total++; if ((d_in - i0) + (d_err - r0) !== 0) begin bad++; $display("FAIL exit_other_pulses: got=%0d exp=0", (d_in - i0) + (d_err - r0)); end
    total++; if (diverge - v0 !== 0) begin bad++; $display("FAIL exit_model: got=%0d exp=0", diverge - v0); end
  endtask

  task automatic test_glitch();
    int p0, fa_hi, busy_hi, len;
    for (int g = 0; g < 2; g++) begin
      len = (g == 0) ? DEBOUNCE - 1 : int'($urandom_range(1, DEBOUNCE - 1));
      p0 = d_in + d_out + d_err;
      fa_hi = 0; busy_hi = 0;
      sensA = 1'b1; sensB = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (c == len) sensA = 1'b0;
        @(negedge clk);
        if (dut.fa !== 1'b0) fa_hi++;
        if (busy !== 1'b0) busy_hi++;
      end
      total++; if (fa_hi !== 0) begin bad++; $display("FAIL glitch_fa len=%0d: got=%0d exp=0", len, fa_hi); end
      total++; if (busy_hi + (d_in + d_out + d_err - p0) !== 0) begin bad++; $display("FAIL glitch_activity len=%0d: got=%0d exp=0", len, busy_hi + (d_in + d_out + d_err - p0)); end
    end
  endtask

  task automatic test_illegal_timeout();
    int i0, o0, r0, v0;
    i0 = d_in; o0 = d_out; r0 = d_err; v0 = diverge;
    hold(2'b00, 20); hold(2'b11, 20);
    total++; if (d_err - r0 !== 1) begin bad++; $display("FAIL illegal_err: got=%0d exp=1", d_err - r0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL illegal_wait_busy: got=%b exp=1", busy); end
    hold(2'b00, 20);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_clear: got=%b exp=0", busy); end
    r0 = d_err;
    hold(2'b10, 100);
    total++; if (d_err - r0 !== 1) begin bad++; $display("FAIL timeout_err: got=%0d exp=1", d_err - r0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL timeout_wait_busy: got=%b exp=1", busy); end
    hold(2'b00, 20);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_clear: got=%b exp=0", busy); end
    total++; if ((d_in - i0) + (d_out - o0) !== 0) begin bad++; $display("FAIL illegal_count_pulses: got=%0d exp=0", (d_in - i0) + (d_out - o0)); end
    total++; if (diverge - v0 !== 0) begin bad++; $display("FAIL illegal_model: got=%0d exp=0", diverge - v0); end
  endtask

  task automatic test_reversal();
    int p0;
    p0 = d_in + d_out + d_err;
    hold(2'b00, 20); hold(2'b10, 20); hold(2'b11, 20); hold(2'b10, 20); hold(2'b00, 20);
    total++; if (d_in + d_out + d_err - p0 !== 0) begin bad++; $display("FAIL reversal_pulses: got=%0d exp=0", d_in + d_out + d_err - p0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reversal_busy: got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int i0;
    hold(2'b00, 20); hold(2'b10, 20); hold(2'b11, 15);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midreset_precond_busy: got=%b exp=1", busy); end
    i0 = d_in;
    reset = 1'b1; sensA = 1'b0; sensB = 1'b0;
    @(posedge clk); #1;
    total++; if ({carIn, carOut, err, busy} !== 4'b0000) begin bad++; $display("FAIL midreset_outputs: got=%b exp=0000", {carIn, carOut, err, busy}); end
    @(negedge clk);
    hold(2'b00, 2);
    reset = 1'b0;
    hold(2'b00, 20); hold(2'b10, 20); hold(2'b11, 20); hold(2'b01, 20); hold(2'b00, 20);
    total++; if (d_in - i0 !== 1) begin bad++; $display("FAIL midreset_entry: got=%0d exp=1", d_in - i0); end
  endtask

  task automatic test_reset_blocked();
    int r0, p0;
    reset = 1'b1; sensA = 1'b1; sensB = 1'b1;
    repeat (3) @(negedge clk);
    r0 = d_err; p0 = d_in + d_out;
    reset = 1'b0;
    hold(2'b11, 20);
    total++; if (d_err - r0 !== 1) begin bad++; $display("FAIL blocked_err: got=%0d exp=1", d_err - r0); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL blocked_busy: got=%b exp=1", busy); end
    hold(2'b00, 20);
    total++; if ({busy, 1'b0} !== 2'b00 || (d_in + d_out - p0) !== 0) begin bad++; $display("FAIL blocked_release: busy=%b pulses=%0d exp busy=0 pulses=0", busy, d_in + d_out - p0); end
  endtask

  task automatic test_back_to_back();
    int i0, o0, r0, v0;
    i0 = d_in; o0 = d_out; r0 = d_err; v0 = diverge;
    hold(2'b00, 20);
    for (int c = 0; c < 8; c++) begin
      hold(2'b10, $urandom_range(8, 20)); hold(2'b11, $urandom_range(8, 20));
      hold(2'b01, $urandom_range(8, 20)); hold(2'b00, $urandom_range(8, 20));
    end
    hold(2'b00, 10);
    total++; if ((d_in - i0) !== 8 || (d_out - o0) !== 0) begin bad++; $display("FAIL b2b_entries: in=%0d out=%0d exp in=8 out=0", d_in - i0, d_out - o0); end
    for (int c = 0; c < 8; c++) begin
      hold(2'b01, $urandom_range(8, 20)); hold(2'b11, $urandom_range(8, 20));
      hold(2'b10, $urandom_range(8, 20)); hold(2'b00, $urandom_range(8, 20));
    end
    hold(2'b00, 10);
    total++; if ((d_in - i0) !== 8 || (d_out - o0) !== 8) begin bad++; $display("FAIL b2b_exits: in=%0d out=%0d exp in=8 out=8", d_in - i0, d_out - o0); end
    total++; if (d_err - r0 !== 0) begin bad++; $display("FAIL b2b_err: got=%0d exp=0", d_err - r0); end
    total++; if (diverge - v0 !== 0) begin bad++; $display("FAIL b2b_model: got=%0d exp=0", diverge - v0); end
  endtask

  task automatic test_random();
    int v0, r;
    int di0, do0, de0, ei0, eo0, ee0;
    v0 = diverge;
    di0 = d_in; do0 = d_out; de0 = d_err; ei0 = e_in; eo0 = e_out; ee0 = e_err;
    for (int s = 0; s < 150; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      hold(2'($urandom_range(0, 3)), $urandom_range(1, DEBOUNCE - 1));
      else if (r < 9) hold(2'($urandom_range(0, 3)), $urandom_range(DEBOUNCE, 40));
      else            hold(2'($urandom_range(0, 3)), $urandom_range(TIMEOUT + 6, TIMEOUT + 30));
    end
    hold(2'b00, 30);
    total++; if (diverge - v0 !== 0) begin bad++; $display("FAIL random_model: got=%0d exp=0", diverge - v0); end
    total++; if ((d_in - di0) !== (e_in - ei0)) begin bad++; $display("FAIL random_carIn: got=%0d exp=%0d", d_in - di0, e_in - ei0); end
    total++; if ((d_out - do0) !== (e_out - eo0)) begin bad++; $display("FAIL random_carOut: got=%0d exp=%0d", d_out - do0, e_out - eo0); end
    total++; if ((d_err - de0) !== (e_err - ee0)) begin bad++; $display("FAIL random_err: got=%0d exp=%0d", d_err - de0, e_err - ee0); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL pulse_exclusive: got=%0d exp=0", overlap); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_entry();
    test_exit();
    test_glitch();
    test_illegal_timeout();
    test_reversal();
    test_reset_mid();
    test_reset_blocked();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
